accel_spi_reader: RTL and testbench

- Upstream feeder of the axis-latching FIFO stage.
- Reads the X, Y and Z 12-bit acceleration samples from an ADXL362-style SPI accelerometer, one axis after another, and presents them as three 12-bit words.
- Raises a round-done strobe after each complete X/Y/Z round. The FIFO stage turns that strobe into its latch enable.
- Runs on the 100 MHz system clock. Generates SCLK internally.

---
 rtl/accel_spi_reader.sv | 119 +++++++++++
 tb/tb_accel_spi_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: reads X/Y/Z 12-bit samples from an ADXL362-style SPI sensor and publishes them once per round.
// Define ROUND_DONE_STRETCH_EN to hold roundDD high for STRETCH_CYCLES instead of a single-cycle pulse.
module accel_spi_reader #(
  parameter int         CLK_DIV        = 50,
  parameter int         GAP_CYCLES     = 100,
  parameter logic [7:0] RD_CMD         = 8'h0B,
  parameter logic [7:0] X_ADDR         = 8'h0E,
  parameter int         STRETCH_CYCLES = 2000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run_en,
  input  logic        MISO,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_N,
  output logic [11:0] x_reg_temp,
  output logic [11:0] y_reg_temp,
  output logic [11:0] z_reg_temp,
  output logic        roundDD,
  output logic        busy
);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, ROUND_END} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [5:0] r_half;
  logic [1:0] r_axis;
  logic r_sclk, r_cs_n, r_dd;
  logic [31:0] r_tx;
  logic [15:0] r_rx;
  logic [11:0] r_sh_x, r_sh_y, r_sh_z, r_x, r_y, r_z;
  logic w_tick, w_last_half, w_tog, w_start;
  logic [1:0] w_axis_nx;
  logic [7:0] w_addr;
  logic [11:0] w_sample;
  assign w_tick = r_cnt == ((r_state == GAP) ? GAP_END : DIV_END);
  assign w_last_half = r_half == 6'd63;
  // SCLK toggles once leaving CS_SETUP and on every half-period boundary except the last
  assign w_tog = w_tick && (r_state == CS_SETUP || (r_state == SHIFT && !w_last_half));
  assign w_start = w_next == CS_SETUP && r_state != CS_SETUP;
  assign w_axis_nx = (r_state == GAP) ? r_axis + 2'd1 : 2'd0;
  assign w_addr = X_ADDR + {5'd0, w_axis_nx, 1'b0};
  assign w_sample = {r_rx[3:0], r_rx[15:8]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = run_en ? CS_SETUP : IDLE;
      CS_SETUP:  w_next = w_tick ? SHIFT : CS_SETUP;
      SHIFT:     w_next = (w_tick && w_last_half) ? CS_HOLD : SHIFT;
      CS_HOLD:   w_next = w_tick ? GAP : CS_HOLD;
      GAP:       w_next = !w_tick ? GAP : (r_axis == 2'd2) ? ROUND_END : CS_SETUP;
      ROUND_END: w_next = run_en ? CS_SETUP : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_cnt <= '0;
      r_half <= 6'd0;
      r_axis <= 2'd0;
      r_sclk <= 1'b0;
      r_cs_n <= 1'b1;
      r_tx <= 32'd0;
      r_rx <= 16'd0;
      r_sh_x <= 12'd0;
      r_sh_y <= 12'd0;
      r_sh_z <= 12'd0;
      r_x <= 12'd0;
      r_y <= 12'd0;
      r_z <= 12'd0;
    end else begin
      r_cnt <= (w_tick || r_state == IDLE || r_state == ROUND_END) ? '0 : r_cnt + 1'b1;
      r_half <= (r_state == SHIFT) ? r_half + {5'd0, w_tick} : 6'd0;
      r_sclk <= w_tog ? ~r_sclk : r_sclk;
      r_cs_n <= !(w_next inside {CS_SETUP, SHIFT, CS_HOLD});
      r_tx <= w_start ? {RD_CMD, w_addr, 16'h0} : (w_tog && r_sclk) ? {r_tx[30:0], 1'b0} : r_tx;
      r_rx <= (w_tog && !r_sclk) ? {r_rx[14:0], MISO} : r_rx;
      r_sh_x <= (r_state == GAP && w_tick && r_axis == 2'd0) ? w_sample : r_sh_x;
      r_sh_y <= (r_state == GAP && w_tick && r_axis == 2'd1) ? w_sample : r_sh_y;
      r_sh_z <= (r_state == GAP && w_tick && r_axis == 2'd2) ? w_sample : r_sh_z;
      r_axis <= (r_state == GAP && w_tick) ? ((r_axis == 2'd2) ? 2'd0 : r_axis + 2'd1) : r_axis;
      // all three outputs load together so a consumer never sees a mixed round
      r_x <= (r_state == ROUND_END) ? r_sh_x : r_x;
      r_y <= (r_state == ROUND_END) ? r_sh_y : r_y;
      r_z <= (r_state == ROUND_END) ? r_sh_z : r_z;
    end
`ifdef ROUND_DONE_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES);
  logic [SW-1:0] r_stretch;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_stretch <= '0;
      r_dd <= 1'b0;
    end else if (r_state == ROUND_END) begin
      r_stretch <= SW'(STRETCH_CYCLES - 1);
      r_dd <= 1'b1;
    end else if (r_stretch != '0) r_stretch <= r_stretch - 1'b1;
    else r_dd <= 1'b0;
`else
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_dd <= 1'b0;
    else r_dd <= r_state == ROUND_END;
`endif
  assign SCLK = r_sclk;
  assign MOSI = r_tx[31];
  assign CS_N = r_cs_n;
  assign x_reg_temp = r_x;
  assign y_reg_temp = r_y;
  assign z_reg_temp = r_z;
  assign roundDD = r_dd;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: scoreboard bench for accel_spi_reader with a mode-0 sensor model
// that answers according to the register address it receives on MOSI.
module tb_accel_spi_reader;
`ifdef ROUND_DONE_STRETCH_EN
  localparam int DD_LEN = 2000;
`else
  localparam int DD_LEN = 1;
`endif
  localparam int ROUND = 10201;
  localparam logic [35:0] D_OLD = {12'h123, 12'h7FF, 12'h800};
  localparam logic [35:0] D_NEW = {12'h456, 12'h234, 12'h789};
  logic CLK = 1'b0, RST = 1'b1, run_en = 1'b0, MISO = 1'b0;
  logic SCLK, MOSI, CS_N, roundDD, busy;
  logic [11:0] x_reg_temp, y_reg_temp, z_reg_temp;
  logic [7:0] sl [3];
  logic [7:0] sh [3];
  logic [35:0] exp_q [$];
  logic [31:0] mcap = 32'd0;
  logic [15:0] dsr = 16'd0;
  int rise = 0;
  int n_pass = 0, n_chk = 0;

  accel_spi_reader dut (
    .CLK(CLK), .RST(RST), .run_en(run_en), .MISO(MISO),
    .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N),
    .x_reg_temp(x_reg_temp), .y_reg_temp(y_reg_temp), .z_reg_temp(z_reg_temp),
    .roundDD(roundDD), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CS_N or posedge SCLK)
    if (SCLK) begin
      mcap = {mcap[30:0], MOSI};
      rise = rise + 1;
    end else rise = 0;

  always @(negedge SCLK)
    if (!CS_N && rise >= 16) begin
      if (rise == 16)
        dsr = (mcap[7:0] == 8'h0E) ? {sl[0], sh[0]} : (mcap[7:0] == 8'h10) ? {sl[1], sh[1]} :
              (mcap[7:0] == 8'h12) ? {sl[2], sh[2]} : 16'hFFFF;
      MISO = dsr[15];
      dsr = {dsr[14:0], 1'b0};
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    run_en = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({SCLK, MOSI, CS_N, roundDD, busy, x_reg_temp, y_reg_temp, z_reg_temp} !== {3'b001, 2'b00, 36'h0})
      $display("FAIL reset_outputs: got %b expected %b", {SCLK, MOSI, CS_N, roundDD, busy, x_reg_temp, y_reg_temp, z_reg_temp}, {3'b001, 2'b00, 36'h0});
    else n_pass++;
    @(negedge CLK) RST = 1'b0;
    repeat (20) tick();
    n_chk++;
    if ({busy, CS_N, SCLK} !== 3'b010) $display("FAIL idle_no_run: got busy/cs_n/sclk %b expected 010", {busy, CS_N, SCLK});
    else n_pass++;
  endtask

  task automatic test_first_round();
    int n = 0, first = -1, dd_len = 0, early = 0, rises = 0, hi = 0, hi_bad = 0, hi_tot = 0;
    int gap = 0, gap_min = 1 << 20, wins = 0;
    logic pcs = 1'b1, psc = 1'b0;
    logic [31:0] fr = 32'd0;
    logic [31:0] frames [$];
    int wr [$];
    logic [35:0] e;
    sl = '{8'h23, 8'hFF, 8'h00};
    sh = '{8'hF1, 8'h07, 8'h08};
    exp_q.push_back(D_OLD);
    @(negedge CLK) run_en = 1'b1;
    while (!(first >= 0 && !roundDD) && n < ROUND + DD_LEN + 200) begin
      tick();
      if (first < 0 && roundDD) begin
        first = n;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL round1_data: roundDD with empty scoreboard");
        else begin
          e = exp_q.pop_front();
          if ({x_reg_temp, y_reg_temp, z_reg_temp} !== e) $display("FAIL round1_data: got %h expected %h", {x_reg_temp, y_reg_temp, z_reg_temp}, e);
          else n_pass++;
        end
      end
      if (roundDD) dd_len++;
      if (first < 0 && {x_reg_temp, y_reg_temp, z_reg_temp} !== 36'h0) early++;
      if (wins < 3) begin
        if (pcs && !CS_N) begin
          rises = 0;
          fr = 32'd0;
          if (wins > 0 && gap < gap_min) gap_min = gap;
        end
        if (!CS_N && SCLK && !psc) begin
          rises++;
          fr = {fr[30:0], MOSI};
        end
        if (SCLK) hi++;
        else if (psc) begin
          hi_tot++;
          if (hi != 50) hi_bad++;
          hi = 0;
        end
        if (!pcs && CS_N) begin
          frames.push_back(fr);
          wr.push_back(rises);
          wins++;
          gap = 0;
        end
        if (CS_N) gap++;
      end
      pcs = CS_N;
      psc = SCLK;
      n++;
    end
    n_chk++;
    if (first != ROUND) $display("FAIL round1_latency: roundDD after %0d edges expected %0d", first, ROUND);
    else n_pass++;
    n_chk++;
    if (early != 0) $display("FAIL outputs_before_round: %0d nonzero samples expected 0", early);
    else n_pass++;
    n_chk++;
    if (dd_len != DD_LEN) $display("FAIL roundDD_width: got %0d expected %0d", dd_len, DD_LEN);
    else n_pass++;
    n_chk++;
    if (frames.size() != 3) $display("FAIL frame_count: got %0d expected 3", frames.size());
    else n_pass++;
    for (int i = 0; i < frames.size(); i++) begin
      n_chk++;
      if (frames[i] !== {8'h0B, 8'h0E + 8'(2 * i), 16'h0}) $display("FAIL mosi_frame%0d: got %h expected %h", i, frames[i], {8'h0B, 8'h0E + 8'(2 * i), 16'h0});
      else n_pass++;
      n_chk++;
      if (wr[i] != 32) $display("FAIL sclk_rises%0d: got %0d expected 32", i, wr[i]);
      else n_pass++;
    end
    n_chk++;
    if (hi_bad != 0 || hi_tot != 96) $display("FAIL sclk_high_time: %0d bad of %0d pulses expected 0 of 96", hi_bad, hi_tot);
    else n_pass++;
    n_chk++;
    if (gap_min < 100) $display("FAIL cs_gap: got %0d expected >= 100", gap_min);
    else n_pass++;
  endtask

  task automatic test_data_change();
    int n = 0, hold_bad = 0, t2 = -1, t3 = -1;
    logic pdd = roundDD;
    logic [35:0] e;
    exp_q.push_back(D_OLD);
    while (t3 < 0 && n < 2 * ROUND + DD_LEN + 200) begin
      tick();
      if (roundDD && !pdd) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL round_data: roundDD with empty scoreboard");
        else begin
          e = exp_q.pop_front();
          if ({x_reg_temp, y_reg_temp, z_reg_temp} !== e) $display("FAIL round_data: got %h expected %h", {x_reg_temp, y_reg_temp, z_reg_temp}, e);
          else n_pass++;
        end
        if (t2 < 0) begin
          t2 = n;
          sl = '{8'h56, 8'h34, 8'h89};
          sh = '{8'h04, 8'hA2, 8'h57};
          exp_q.push_back(D_NEW);
        end else t3 = n;
      end else if (t2 >= 0 && {x_reg_temp, y_reg_temp, z_reg_temp} !== D_OLD) hold_bad++;
      pdd = roundDD;
      n++;
    end
    n_chk++;
    if (t3 < 0 || t3 - t2 != ROUND) $display("FAIL round_period: got %0d expected %0d", t3 - t2, ROUND);
    else n_pass++;
    n_chk++;
    if (hold_bad != 0) $display("FAIL hold_old_data: %0d cycles changed early expected 0", hold_bad);
    else n_pass++;
  endtask

  task automatic test_drop_run_en();
    int n = 0, wins = 0, rises = 0, idle = -1, idle_bad = 0, drop_at = -1;
    logic pcs = 1'b1, pdd = roundDD;
    logic [35:0] e;
    exp_q.push_back(D_NEW);
    while (n < 2 * ROUND && !(idle >= 0 && n - idle >= 1000)) begin
      tick();
      if (pcs && !CS_N) begin
        wins++;
        if (wins == 2) drop_at = n + 500;
      end
      if (n == drop_at) run_en = 1'b0;
      if (roundDD && !pdd) begin
        rises++;
        if (rises == 1) begin
          n_chk++;
          if (exp_q.size() == 0) $display("FAIL drop_data: roundDD with empty scoreboard");
          else begin
            e = exp_q.pop_front();
            if ({x_reg_temp, y_reg_temp, z_reg_temp} !== e) $display("FAIL drop_data: got %h expected %h", {x_reg_temp, y_reg_temp, z_reg_temp}, e);
            else n_pass++;
          end
        end
      end
      if (idle < 0 && !busy) idle = n;
      if (idle >= 0 && (busy || !CS_N)) idle_bad++;
      pcs = CS_N;
      pdd = roundDD;
      n++;
    end
    n_chk++;
    if (wins != 3) $display("FAIL drop_windows: got %0d expected 3", wins);
    else n_pass++;
    n_chk++;
    if (rises != 1) $display("FAIL drop_strobes: got %0d expected 1", rises);
    else n_pass++;
    n_chk++;
    if (idle < 0 || idle_bad != 0) $display("FAIL drop_idle: idle at %0d with %0d busy cycles expected 0", idle, idle_bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0, wins = 0, rises = 0, bad = 0, first = -1, zero_bad = 0;
    logic hit = 1'b0, pcs = 1'b1, psc = 1'b0;
    logic [31:0] fr = 32'd0;
    logic [35:0] e;
    @(negedge CLK) run_en = 1'b1;
    while (!hit && n < ROUND + 200) begin
      tick();
      if (pcs && !CS_N) begin
        wins++;
        rises = 0;
      end
      if (!CS_N && SCLK && !psc) rises++;
      if (wins == 3 && rises == 10) hit = 1'b1;
      if (roundDD) bad++;
      pcs = CS_N;
      psc = SCLK;
      n++;
    end
    n_chk++;
    if (!hit) $display("FAIL reach_z_shift: got wins %0d rises %0d expected 3 and 10", wins, rises);
    else n_pass++;
    RST = 1'b1;
    #1;
    n_chk++;
    if ({SCLK, MOSI, CS_N, roundDD, busy, x_reg_temp, y_reg_temp, z_reg_temp} !== {3'b001, 2'b00, 36'h0})
      $display("FAIL async_reset: got %b expected %b", {SCLK, MOSI, CS_N, roundDD, busy, x_reg_temp, y_reg_temp, z_reg_temp}, {3'b001, 2'b00, 36'h0});
    else n_pass++;
    repeat (3) begin
      tick();
      if (roundDD || !CS_N || SCLK) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL reset_quiet: got %0d bad cycles expected 0", bad);
    else n_pass++;
    exp_q.push_back(D_NEW);
    @(negedge CLK) RST = 1'b0;
    n = 0;
    wins = 0;
    rises = 0;
    pcs = 1'b1;
    psc = 1'b0;
    while (first < 0 && n < ROUND + 200) begin
      tick();
      if (pcs && !CS_N) wins++;
      if (wins == 1 && !CS_N && SCLK && !psc) begin
        rises++;
        if (rises <= 16) fr = {fr[30:0], MOSI};
      end
      if (roundDD) begin
        first = n;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL fresh_data: roundDD with empty scoreboard");
        else begin
          e = exp_q.pop_front();
          if ({x_reg_temp, y_reg_temp, z_reg_temp} !== e) $display("FAIL fresh_data: got %h expected %h", {x_reg_temp, y_reg_temp, z_reg_temp}, e);
          else n_pass++;
        end
      end else if ({x_reg_temp, y_reg_temp, z_reg_temp} !== 36'h0) zero_bad++;
      pcs = CS_N;
      psc = SCLK;
      n++;
    end
    n_chk++;
    if (first != ROUND) $display("FAIL fresh_latency: got %0d expected %0d", first, ROUND);
    else n_pass++;
    n_chk++;
    if (fr[15:0] !== 16'h0B0E) $display("FAIL fresh_from_x: got %h expected 0b0e", fr[15:0]);
    else n_pass++;
    n_chk++;
    if (zero_bad != 0) $display("FAIL no_partial_publish: got %0d nonzero cycles expected 0", zero_bad);
    else n_pass++;
    run_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_data_change();
    test_drop_run_en();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
